// File: rtl/pmod_io_pkg.sv
// -----------------------------------------------------------------------------
// pmod_io_pkg
// Shared definitions for the PMOD button/LED controller:
//   - bit positions of the fields inside the CPU control word (OPORT)
//   - bit positions of the fields inside the status word (IPORT)
//   - debouncer FSM state encoding
// -----------------------------------------------------------------------------
package pmod_io_pkg;

  // OPORT (CPU -> controller) field positions
  localparam int LED_ON_LSB = 0;
  localparam int BLINK_LSB  = 4;
  localparam int DUTY_LSB   = 8;
  localparam int DUTY_W     = 8;
  localparam int CLR_BIT    = 16;
  localparam int IRQEN_BIT  = 17;

  // IPORT (controller -> CPU) field positions
  localparam int STATE_LSB  = 0;
  localparam int PRESS_LSB  = 4;
  localparam int REL_LSB    = 8;

  // Debouncer FSM states
  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } db_state_e;

endpackage

// File: rtl/pmod_debounce.sv
// -----------------------------------------------------------------------------
// pmod_debounce
// One-button input conditioner: 2-FF synchronizer, STABLE/SETTLE debounce FSM
// with a saturating-compare counter, and registered one-cycle edge pulses.
//
// Ports:
//   clk      in   system clock, all state on rising edge
//   rst      in   asynchronous, active-high reset
//   btn_raw  in   raw button level, asynchronous to clk
//   stable   out  debounced button level
//   rise     out  one-cycle pulse when stable goes 0 -> 1
//   fall     out  one-cycle pulse when stable goes 1 -> 0
//
// A change on the synchronized input is accepted after DEBOUNCE consecutive
// cycles of disagreement with the current stable level.
// -----------------------------------------------------------------------------
module pmod_debounce
  import pmod_io_pkg::*;
#(
  parameter int DEBOUNCE = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int             CW       = $clog2(DEBOUNCE);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1_q, sync2_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Synchronizer: btn_raw is asynchronous, so only sync2_q is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // FSM state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= STABLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  // Next-state logic. The first disagreeing cycle is counted as 1 on the
  // STABLE->SETTLE transition, so acceptance happens on the DEBOUNCE-th
  // consecutive disagreeing cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    case (state_q)
      STABLE: begin
        if (sync2_q != stable_q) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end
      end
      SETTLE: begin
        if (sync2_q == stable_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE;
          cnt_d    = '0;
          stable_d = sync2_q;
          rise_d   = sync2_q;
          fall_d   = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/pmod_io_ctrl.sv
// -----------------------------------------------------------------------------
// pmod_io_ctrl
// Glue between the SoC general-purpose ports and the PMOD button/LED adapter.
// Buttons are synchronized and debounced; press/release events latch into
// sticky flags with a level interrupt. LEDs are driven from the CPU control
// word with per-LED on/off, blink and a shared 8-bit PWM duty.
//
// Ports:
//   XCLK     in   system clock
//   XRES     in   asynchronous, active-high reset
//   BTN_RAW  in   [NBTN] raw buttons, active-high, asynchronous
//   OPORT    in   [32] control: [3:0] LED on, [7:4] blink en, [15:8] duty,
//                 [16] event clear (rising edge), [17] IRQ enable
//   IPORT    out  [32] status: [3:0] debounced state, [7:4] press flags,
//                 [11:8] release flags, rest zero
//   PM_LEDS  out  [NBTN] LED drive, active-high
//   IRQ      out  event interrupt, level, active-high
// -----------------------------------------------------------------------------
module pmod_io_ctrl
  import pmod_io_pkg::*;
#(
  parameter int NBTN      = 4,
  parameter int DEBOUNCE  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic            XCLK,
  input  logic            XRES,
  input  logic [NBTN-1:0] BTN_RAW,
  input  logic [31:0]     OPORT,
  output logic [31:0]     IPORT,
  output logic [NBTN-1:0] PM_LEDS,
  output logic            IRQ
);

  localparam int            BW         = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] PRESC_LAST = BW'(BLINK_DIV - 1);

  // Debouncer outputs
  logic [NBTN-1:0] db_stable, db_rise, db_fall;

  // Registered state
  logic [NBTN-1:0]   state_q, state_d;
  logic [NBTN-1:0]   press_q, press_d;
  logic [NBTN-1:0]   rel_q, rel_d;
  logic              clr_hist_q, clr_hist_d;
  logic              irq_q, irq_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BW-1:0]     presc_q, presc_d;
  logic              blink_ph_q, blink_ph_d;
  logic [NBTN-1:0]   leds_q, leds_d;

  logic              clr_edge;
  logic [DUTY_W-1:0] duty;
  logic [NBTN-1:0]   led_term;
  logic              unused_oport;

  // Bits above the IRQ enable carry no function.
  assign unused_oport = ^OPORT[31:IRQEN_BIT+1];

  generate
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
      pmod_debounce #(
        .DEBOUNCE (DEBOUNCE)
      ) u_db (
        .clk     (XCLK),
        .rst     (XRES),
        .btn_raw (BTN_RAW[gi]),
        .stable  (db_stable[gi]),
        .rise    (db_rise[gi]),
        .fall    (db_fall[gi])
      );
    end
  endgenerate

  assign duty = OPORT[DUTY_LSB +: DUTY_W];

  // Per-LED drive term: enabled, blink phase gating, PWM compare.
  // Using <= makes duty 0xFF fully on and duty 0x00 one cycle in 256.
  generate
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_led
      assign led_term[gi] = OPORT[LED_ON_LSB + gi]
                          & (~OPORT[BLINK_LSB + gi] | blink_ph_q)
                          & (pwm_cnt_q <= duty);
    end
  endgenerate

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      state_q    <= '0;
      press_q    <= '0;
      rel_q      <= '0;
      clr_hist_q <= 1'b0;
      irq_q      <= 1'b0;
      pwm_cnt_q  <= '0;
      presc_q    <= '0;
      blink_ph_q <= 1'b0;
      leds_q     <= '0;
    end else begin
      state_q    <= state_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      clr_hist_q <= clr_hist_d;
      irq_q      <= irq_d;
      pwm_cnt_q  <= pwm_cnt_d;
      presc_q    <= presc_d;
      blink_ph_q <= blink_ph_d;
      leds_q     <= leds_d;
    end
  end

  always_comb begin
    clr_edge   = OPORT[CLR_BIT] & ~clr_hist_q;
    clr_hist_d = OPORT[CLR_BIT];

    // Clear first, then OR in new events so a coincident event survives.
    press_d = (clr_edge ? '0 : press_q) | db_rise;
    rel_d   = (clr_edge ? '0 : rel_q)   | db_fall;

    // Re-registering the debounced level aligns it with the flags in IPORT.
    state_d = db_stable;

    irq_d = OPORT[IRQEN_BIT] & ((|press_q) | (|rel_q));

    pwm_cnt_d  = pwm_cnt_q + DUTY_W'(1);
    presc_d    = presc_q + BW'(1);
    blink_ph_d = blink_ph_q;
    if (presc_q == PRESC_LAST) begin
      presc_d    = '0;
      blink_ph_d = ~blink_ph_q;
    end

    leds_d = led_term;
  end

  always_comb begin
    IPORT = '0;
    IPORT[STATE_LSB +: NBTN] = state_q;
    IPORT[PRESS_LSB +: NBTN] = press_q;
    IPORT[REL_LSB   +: NBTN] = rel_q;
  end

  assign PM_LEDS = leds_q;
  assign IRQ     = irq_q;

endmodule

// File: tb/tb_pmod_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pmod_io_ctrl
// Self-checking bench: a cycle-level behavioural model (run-length debounce,
// cycle-count derived PWM/blink) is compared against the DUT every cycle,
// plus directed scenarios with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_pmod_io_ctrl;

  localparam int NBTN      = 4;
  localparam int DEBOUNCE  = 4;
  localparam int BLINK_DIV = 8;

  logic        XCLK;
  logic        XRES;
  logic [3:0]  BTN_RAW;
  logic [31:0] OPORT;
  logic [31:0] IPORT;
  logic [3:0]  PM_LEDS;
  logic        IRQ;

  int errors = 0;
  int checks = 0;
  int printed = 0;

  pmod_io_ctrl #(
    .NBTN      (NBTN),
    .DEBOUNCE  (DEBOUNCE),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .XCLK    (XCLK),
    .XRES    (XRES),
    .BTN_RAW (BTN_RAW),
    .OPORT   (OPORT),
    .IPORT   (IPORT),
    .PM_LEDS (PM_LEDS),
    .IRQ     (IRQ)
  );

  initial XCLK = 1'b0;
  always #5 XCLK = ~XCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (printed < 40) begin
        printed++;
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Raw samples are delayed two cycles (synchronizer);
  // a change is accepted once the delayed input has disagreed with the
  // accepted level for DEBOUNCE consecutive cycles. Accepted events reach
  // the visible flags one cycle later. PWM and blink come from the number
  // of cycles since reset.
  // ---------------------------------------------------------------------------
  int unsigned m_cyc;
  int          m_run [4];
  logic [3:0]  m_r1, m_r2, m_s, m_stable, m_pr, m_pf;
  logic [3:0]  m_press, m_rel, m_vis, m_leds;
  logic        m_irq, m_clrh, m_ph;
  int          m_pwm;

  initial begin
    m_cyc = 0; m_r1 = 0; m_r2 = 0; m_stable = 0; m_pr = 0; m_pf = 0;
    m_press = 0; m_rel = 0; m_vis = 0; m_leds = 0; m_irq = 0; m_clrh = 0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  end

  always @(posedge XCLK) begin
    if (XRES) begin
      m_cyc = 0; m_r1 = 0; m_r2 = 0; m_stable = 0; m_pr = 0; m_pf = 0;
      m_press = 0; m_rel = 0; m_vis = 0; m_leds = 0; m_irq = 0; m_clrh = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      m_irq = OPORT[17] & ((|m_press) | (|m_rel));
      if (OPORT[16] && !m_clrh) begin
        m_press = 0;
        m_rel   = 0;
      end
      m_press = m_press | m_pr;
      m_rel   = m_rel | m_pf;
      m_clrh  = OPORT[16];
      m_vis   = m_stable;

      m_pwm = int'(m_cyc % 256);
      m_ph  = ((m_cyc / BLINK_DIV) % 2) == 1;
      for (int i = 0; i < 4; i++)
        m_leds[i] = OPORT[i] & (!OPORT[4+i] | m_ph) & (m_pwm <= int'(OPORT[15:8]));

      m_s  = m_r2;
      m_r2 = m_r1;
      m_r1 = BTN_RAW;
      m_pr = 0;
      m_pf = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_s[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DEBOUNCE) begin
            m_stable[i] = m_s[i];
            m_pr[i]     = m_s[i];
            m_pf[i]     = !m_s[i];
            m_run[i]    = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_cyc++;
    end
  end

  // Per-cycle comparison, sampled just after the active edge.
  always @(posedge XCLK) begin
    #1;
    check("model_iport", IPORT, {20'b0, m_rel, m_press, m_vis});
    check("model_leds", {28'b0, PM_LEDS}, {28'b0, m_leds});
    check("model_irq", {31'b0, IRQ}, {31'b0, m_irq});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge XCLK);
      @(negedge XCLK);
    end
  endtask

  int hi0, hi2;

  initial begin
    XRES    = 1'b1;
    BTN_RAW = 4'hF;
    OPORT   = 32'h0;
    step(3);
    check("rst_iport", IPORT, 32'h0);
    check("rst_leds", {28'b0, PM_LEDS}, 32'h0);
    check("rst_irq", {31'b0, IRQ}, 32'h0);

    // Buttons held through reset appear as presses after debounce.
    XRES = 1'b0;
    step(6);
    check("rst_lat_early", IPORT, 32'h0);
    step(1);
    check("rst_lat", IPORT, 32'hFF);

    BTN_RAW = 4'h0;
    step(20);
    check("all_released", IPORT, 32'hFF0);
    OPORT = 32'h0001_0000;
    step(1);
    check("clr_all", IPORT, 32'h0);
    OPORT = 32'h0;
    step(2);

    // Glitch of 3 cycles is rejected.
    BTN_RAW = 4'h1;
    step(3);
    BTN_RAW = 4'h0;
    step(10);
    check("glitch", IPORT, 32'h0);

    // Held press with IRQ enabled.
    OPORT   = 32'h0002_0000;
    BTN_RAW = 4'h1;
    step(6);
    check("press_early", IPORT, 32'h0);
    step(1);
    check("press", IPORT, 32'h11);
    check("press_irq_lag", {31'b0, IRQ}, 32'h0);
    step(1);
    check("press_irq", {31'b0, IRQ}, 32'h1);

    // Release, then clear.
    BTN_RAW = 4'h0;
    step(7);
    check("release", IPORT, 32'h110);
    OPORT = 32'h0003_0000;
    step(1);
    check("clr_flags", IPORT, 32'h0);
    check("clr_irq_hold", {31'b0, IRQ}, 32'h1);
    step(1);
    check("clr_irq", {31'b0, IRQ}, 32'h0);

    // Clear edge coincides with the press of button 2.
    OPORT   = 32'h0002_0000;
    BTN_RAW = 4'h2;
    step(8);
    check("pre_coll", IPORT, 32'h22);
    BTN_RAW = 4'h6;
    step(6);
    OPORT = 32'h0003_0000;
    step(1);
    check("collision", IPORT, 32'h46);

    OPORT   = 32'h0;
    BTN_RAW = 4'h0;
    step(12);
    OPORT = 32'h0001_0000;
    step(1);
    OPORT = 32'h0;
    step(1);

    // Steady LEDs.
    OPORT = 32'h0000_FF05;
    step(2);
    for (int k = 0; k < 20; k++) begin
      check("led_steady", {28'b0, PM_LEDS}, 32'h5);
      step(1);
    end

    // Blink: over 4 whole blink periods LED0 is on half the time.
    OPORT = 32'h0000_FF15;
    step(2);
    hi0 = 0;
    hi2 = 0;
    for (int k = 0; k < 64; k++) begin
      hi0 += int'(PM_LEDS[0]);
      hi2 += int'(PM_LEDS[2]);
      step(1);
    end
    check("blink_led0", hi0, 32);
    check("blink_led2", hi2, 64);

    // PWM: duty 0x3F gives 64 of 256 cycles.
    OPORT = 32'h0000_3F01;
    step(2);
    hi0 = 0;
    for (int k = 0; k < 256; k++) begin
      hi0 += int'(PM_LEDS[0]);
      step(1);
    end
    check("pwm_64", hi0, 64);

    // Random stimulus with a reset in the middle of activity.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) BTN_RAW[b] = ~BTN_RAW[b];
      if ($urandom_range(0, 15) == 0) OPORT = $urandom;
      if ($urandom_range(0, 7) == 0) OPORT[16] = ~OPORT[16];
      if (c == 1500) XRES = 1'b1;
      if (c == 1502) XRES = 1'b0;
      step(1);
    end

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
